// File: rtl/dmem_responder_if.sv
// Load/store bus between the core's memory port and the data-memory responder.
// The core drives the master side; the responder implements the slave side.
interface dmem_responder_if #(
  parameter int ADDR_W = 12
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_sel;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_sel, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_sel, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed wait states, byte lanes.
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned H/W accesses instead of aligning them.
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [2:0]        sel_reg;
  logic [31:0]       wdata_reg;
  logic              req_ready_reg;
  logic              rsp_valid_reg;
  logic [31:0]       rsp_rdata_reg;
  logic              rsp_err_reg;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_word_reg;

  logic [1:0]        size;
  logic              is_unsigned;
  logic              illegal_sel;
  logic              misaligned;
  logic [1:0]        lane_raw;
  logic [1:0]        lane;
  logic              access_err;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       shifted;
  logic [31:0]       load_val;
  logic              exec;
  logic              mem_we;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;

  assign size        = sel_reg[1:0];
  assign is_unsigned = sel_reg[2];
  assign illegal_sel = (size == 2'b11) || (sel_reg == 3'b110);
  assign lane_raw    = addr_reg[1:0];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = ((size == 2'b01) && lane_raw[0]) ||
                      ((size == 2'b10) && (lane_raw != 2'b00));
  assign lane       = lane_raw;
`else
  assign misaligned = 1'b0;
  always_comb begin
    lane = lane_raw;
    if (size == 2'b10) begin
      lane = 2'b00;
    end else if (size == 2'b01) begin
      lane = {lane_raw[1], 1'b0};
    end
  end
`endif

  assign access_err = illegal_sel | misaligned;

  // Store data is replicated so every lane sees the right bytes; lane_be picks which land.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_be[gi] = (size == 2'b10) ||
                           ((size == 2'b01) && (lane[1] == LANE[1])) ||
                           ((size == 2'b00) && (lane == LANE));
      assign lane_wdata[8*gi +: 8] = (size == 2'b00) ? wdata_reg[7:0] :
                                     (size == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                                       wdata_reg[8*gi +: 8];
    end
  endgenerate

  assign shifted = rd_word_reg >> {lane, 3'b000};

  always_comb begin
    load_val = rd_word_reg;
    case (size)
      2'b00:   load_val = is_unsigned ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = is_unsigned ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = rd_word_reg;
    endcase
  end

  assign exec   = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign mem_we = exec && we_reg && !access_err;
  assign wr_idx = addr_reg[ADDR_W-1:2];
  // Read the incoming address while idle so the word is ready even with zero wait states.
  assign rd_idx = (state_reg == IDLE) ? bus.req_addr[ADDR_W-1:2] : wr_idx;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) begin
          mem[wr_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
        end
      end
    end
    rd_word_reg <= mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      sel_reg       <= 3'b000;
      wdata_reg     <= 32'd0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            we_reg        <= bus.req_we;
            addr_reg      <= bus.req_addr;
            sel_reg       <= bus.req_sel;
            wdata_reg     <= bus.req_wdata;
            cnt_reg       <= 4'(WAIT_CYCLES);
            req_ready_reg <= 1'b0;
            state_reg     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg == 4'd0) begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= access_err;
            rsp_rdata_reg <= (we_reg || access_err) ? 32'd0 : load_val;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;

endmodule
